// File: rtl/pll_lock_seq_pkg.sv
// Shared state encoding, synchronizer depth and counter sizing for the PLL lock sequencer.
package pll_lock_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWR_DOWN  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_HOLD_RST  = 3'd4,
        ST_READY     = 3'd5,
        ST_FAILED    = 3'd6
    } state_e;

    localparam int SYNC_STAGES = 2;

    // Bits needed to count 0 .. cycles-1, never less than one.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_seq_sync.sv
// N-flop synchronizer for a single asynchronous level, cleared by async reset (STAGES >= 2).
module pll_lock_seq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL enable / lock qualification sequencer with bounded retries and user reset release.
// Optional lock-loss event counter is built when PLL_LOCK_SEQ_LOSS_CNT_EN is defined.
module pll_lock_sequencer
    import pll_lock_seq_pkg::*;
#(
    parameter int EN_DELAY_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int MAX_RETRIES        = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          PLL_LOCK,
    output logic          PLL_EN,
    output logic          USER_RESET,
    output logic          PLL_READY,
    output logic          FAIL,
    output logic [RW-1:0] RETRY_CNT,
    output logic [2:0]    STATE
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]    LOCK_LOSS_CNT
`endif
);

    localparam int MAX_A   = (EN_DELAY_CYCLES > LOCK_TIMEOUT) ? EN_DELAY_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CW      = cnt_width((MAX_A > MAX_B) ? MAX_A : MAX_B);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            pll_en_q, pll_en_d;
    logic            user_rst_q, user_rst_d;
    logic            ready_q, ready_d;
    logic            fail_q, fail_d;
    logic            lock_s;

    pll_lock_seq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (PLL_LOCK),
        .q_o   (lock_s)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            pll_en_q   <= 1'b0;
            user_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            pll_en_q   <= pll_en_d;
            user_rst_q <= user_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        if (!START) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PWR_DOWN;
                    retry_d = '0;
                end
                ST_PWR_DOWN: begin
                    if (cnt_q == CW'(EN_DELAY_CYCLES - 1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the final timeout cycle still counts as a lock.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        if (retry_q < RW'(MAX_RETRIES)) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_PWR_DOWN;
                        end else begin
                            state_d = ST_FAILED;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) state_d = ST_WAIT_LOCK;
                    else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) state_d = ST_HOLD_RST;
                end
                ST_HOLD_RST: begin
                    if (!lock_s) state_d = ST_WAIT_LOCK;
                    else if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) state_d = ST_READY;
                end
                ST_READY: begin
                    if (!lock_s) begin
                        state_d = ST_PWR_DOWN;
                        retry_d = '0;
                    end
                end
                ST_FAILED: state_d = ST_FAILED;
                default:   state_d = ST_IDLE;
            endcase
        end
        // Every timed state starts counting from zero on entry.
        if (state_d != state_q || state_q inside {ST_IDLE, ST_READY, ST_FAILED}) cnt_d = '0;
    end

    always_comb begin
        pll_en_d   = state_d inside {ST_WAIT_LOCK, ST_STABLE, ST_HOLD_RST, ST_READY};
        user_rst_d = (state_d != ST_READY);
        ready_d    = (state_d == ST_READY);
        fail_d     = (state_d == ST_FAILED);
    end

    assign PLL_EN     = pll_en_q;
    assign USER_RESET = user_rst_q;
    assign PLL_READY  = ready_q;
    assign FAIL       = fail_q;
    assign RETRY_CNT  = retry_q;
    assign STATE      = state_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;

    // Only power-on reset clears the history; a START drop keeps it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            loss_q <= '0;
        end else if (state_q == ST_READY && state_d == ST_PWR_DOWN && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign LOCK_LOSS_CNT = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: event-level reference model plus directed and random lock patterns.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int EN_D = 4;
    localparam int TMO  = 32;
    localparam int STB  = 8;
    localparam int HLD  = 4;
    localparam int MR   = 2;

    localparam int S_IDLE = 0, S_PWR = 1, S_WAIT = 2, S_STB = 3, S_HOLD = 4, S_RDY = 5, S_FAIL = 6;

    logic       CLK = 1'b0;
    logic       RESET, START, PLL_LOCK;
    logic       PLL_EN, USER_RESET, PLL_READY, FAIL;
    logic [1:0] RETRY_CNT;
    logic [2:0] STATE;
    logic [7:0] loss_dut;

    pll_lock_sequencer #(
        .EN_DELAY_CYCLES    (EN_D),
        .LOCK_TIMEOUT       (TMO),
        .LOCK_STABLE_CYCLES (STB),
        .RST_HOLD_CYCLES    (HLD),
        .MAX_RETRIES        (MR)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .PLL_LOCK   (PLL_LOCK),
        .PLL_EN     (PLL_EN),
        .USER_RESET (USER_RESET),
        .PLL_READY  (PLL_READY),
        .FAIL       (FAIL),
        .RETRY_CNT  (RETRY_CNT),
        .STATE      (STATE)
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        ,
        .LOCK_LOSS_CNT (loss_dut)
`endif
    );

`ifndef PLL_LOCK_SEQ_LOSS_CNT_EN
    assign loss_dut = 8'd0;
`endif

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [16:0] v;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 0;
    logic [16:0] mon_prev;

    // Reference model: state number, cycles already spent in it, retry/loss counts, lock samples in flight.
    int          m_state, m_t, m_retry, m_loss;
    logic        lk1, lk2;
    logic [16:0] m_vec;

    function automatic logic [16:0] exp_vec(input int st, input int rc, input int lc);
        logic [7:0] l;
        logic [1:0] r;
        logic [2:0] s;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        l = lc[7:0];
`else
        l = 8'd0;
`endif
        r = rc[1:0];
        s = st[2:0];
        return {l, (st >= S_WAIT && st <= S_RDY), (st != S_RDY), (st == S_RDY), (st == S_FAIL), r, s};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {loss_dut, PLL_EN, USER_RESET, PLL_READY, FAIL, RETRY_CNT, STATE};
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_t     = 0;
        m_retry = 0;
        m_loss  = 0;
        lk1     = 1'b0;
        lk2     = 1'b0;
        m_vec   = exp_vec(S_IDLE, 0, 0);
    endtask

    task automatic step_model();
        int          nxt, el;
        logic        ls;
        logic [16:0] v;
        exp_t        e;
        ls  = lk2;
        lk2 = lk1;
        lk1 = PLL_LOCK;
        el  = m_t + 1;
        nxt = m_state;
        if (!START) begin
            nxt = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE: begin nxt = S_PWR; m_retry = 0; end
                S_PWR:  if (el == EN_D) nxt = S_WAIT;
                S_WAIT: begin
                    if (ls) nxt = S_STB;
                    else if (el == TMO) begin
                        if (m_retry < MR) begin m_retry++; nxt = S_PWR; end
                        else nxt = S_FAIL;
                    end
                end
                S_STB:  if (!ls) nxt = S_WAIT; else if (el == STB) nxt = S_HOLD;
                S_HOLD: if (!ls) nxt = S_WAIT; else if (el == HLD) nxt = S_RDY;
                S_RDY:  if (!ls) begin nxt = S_PWR; m_retry = 0; if (m_loss < 255) m_loss++; end
                default: ;
            endcase
        end
        m_t     = (nxt != m_state) ? 0 : el;
        m_state = nxt;
        v = exp_vec(m_state, m_retry, m_loss);
        if (v !== m_vec) begin
            e.cyc = cyc;
            e.v   = v;
            sbq.push_back(e);
            m_vec = v;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        step_model();
        #1;
    endtask

    task automatic run_until(input int st, input int max_cyc, input string name);
        int n;
        n = 0;
        while (m_state != st && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, m_state, st);
    endtask

    // Monitor: every change of the DUT output vector must match the next predicted change, on the same cycle.
    always @(negedge CLK) begin
        exp_t        e;
        logic [16:0] v;
        if (mon_en) begin
            v = dut_vec();
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL sb_missed: got %h unchanged, expected %h at cycle %0d", v, e.v, e.cyc);
            end
            if (v !== mon_prev) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h at cycle %0d, expected no change from %h", v, cyc, mon_prev);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || e.v !== v) begin
                        failures++;
                        $display("FAIL sb_change: got %h at cycle %0d, expected %h at cycle %0d", v, cyc, e.v, e.cyc);
                    end
                end
                mon_prev = v;
            end
        end
    end

    initial begin
        int   s0, e0, d0, n, hold;
        exp_t e;
        RESET    = 1'b1;
        START    = 1'b0;
        PLL_LOCK = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_pll_en", PLL_EN, 0);
        check("rst_user_reset", USER_RESET, 1);
        check("rst_pll_ready", PLL_READY, 0);
        check("rst_fail", FAIL, 0);
        check("rst_retry", RETRY_CNT, 0);
        check("rst_state", STATE, S_IDLE);
        check("rst_loss", loss_dut, 0);
        RESET = 1'b0;
        model_reset();
        mon_prev = exp_vec(S_IDLE, 0, 0);
        mon_en   = 1;

        // Nominal bring-up
        START = 1'b1;
        s0 = cyc + 1;
        n = 0;
        while (PLL_EN !== 1'b1 && n < 20) begin tick(); n++; end
        check("en_latency", cyc - s0 + 1, 1 + EN_D);
        repeat (9) tick();
        PLL_LOCK = 1'b1;
        e0 = cyc + 1;
        n = 0;
        while (PLL_READY !== 1'b1 && n < 60) begin tick(); n++; end
        check("ready_latency", cyc - e0 + 1, 2 + 1 + STB + HLD);
        check("ready_user_reset", USER_RESET, 0);
        check("ready_retry", RETRY_CNT, 0);

        // First lock loss in READY
        PLL_LOCK = 1'b0;
        d0 = cyc + 1;
        n = 0;
        while (USER_RESET !== 1'b1 && n < 10) begin tick(); n++; end
        check("loss_latency", cyc - d0 + 1, 3);
        check("loss_pll_en", PLL_EN, 0);
        check("loss_pll_ready", PLL_READY, 0);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        check("loss_cnt_one", loss_dut, 1);
`endif

        // Lock glitch shorter than the stability window
        run_until(S_WAIT, 20, "reach_wait");
        PLL_LOCK = 1'b1;
        repeat (5) tick();
        PLL_LOCK = 1'b0;
        repeat (4) tick();
        check("glitch_state", STATE, S_WAIT);
        check("glitch_ready", PLL_READY, 0);
        check("glitch_pll_en", PLL_EN, 1);
        PLL_LOCK = 1'b1;
        e0 = cyc + 1;
        n = 0;
        while (PLL_READY !== 1'b1 && n < 60) begin tick(); n++; end
        check("relock_latency", cyc - e0 + 1, 2 + 1 + STB + HLD);

        // Repeated lock losses push the loss counter into saturation
        for (int i = 0; i < 299; i++) begin
            PLL_LOCK = 1'b0;
            run_until(S_PWR, 10, "rep_loss");
            PLL_LOCK = 1'b1;
            run_until(S_RDY, 60, "rep_ready");
        end
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        check("loss_cnt_sat", loss_dut, 255);
`endif

        // Abort in STABLE, then async reset while READY
        PLL_LOCK = 1'b0;
        run_until(S_WAIT, 20, "abort_wait");
        PLL_LOCK = 1'b1;
        run_until(S_STB, 10, "abort_stable");
        repeat (3) tick();
        START = 1'b0;
        tick();
        check("abort_state", STATE, S_IDLE);
        check("abort_pll_en", PLL_EN, 0);
        START = 1'b1;
        run_until(S_RDY, 60, "abort_ready");
        if (sbq.size() > 0 && sbq[$].cyc == cyc) void'(sbq.pop_back());
        e.cyc = cyc;
        e.v   = exp_vec(S_IDLE, 0, 0);
        sbq.push_back(e);
        RESET = 1'b1;
        #1;
        check("arst_user_reset", USER_RESET, 1);
        check("arst_pll_ready", PLL_READY, 0);
        check("arst_pll_en", PLL_EN, 0);
        check("arst_state", STATE, S_IDLE);
        #1;
        RESET = 1'b0;
        model_reset();

        // Timeouts with retries until FAILED
        START    = 1'b0;
        PLL_LOCK = 1'b0;
        tick();
        START = 1'b1;
        run_until(S_FAIL, 300, "reach_failed");
        check("failed_flag", FAIL, 1);
        check("failed_pll_en", PLL_EN, 0);
        check("failed_state", STATE, S_FAIL);
        check("failed_retry", RETRY_CNT, MR);
        START = 1'b0;
        tick();
        check("failed_clear_fail", FAIL, 0);
        check("failed_clear_state", STATE, S_IDLE);

        // Lock arriving on the last timeout cycle of the second attempt
        START = 1'b1;
        run_until(S_WAIT, 20, "bnd_wait1");
        run_until(S_PWR, 40, "bnd_retry");
        run_until(S_WAIT, 10, "bnd_wait2");
        repeat (29) tick();
        PLL_LOCK = 1'b1;
        repeat (2) tick();
        check("bnd_before", STATE, S_WAIT);
        tick();
        check("bnd_state", STATE, S_STB);
        check("bnd_retry_cnt", RETRY_CNT, 1);

        // Random lock/start activity
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                PLL_LOCK = ($urandom_range(0, 3) != 0);
                hold     = $urandom_range(1, 40);
            end
            hold--;
            START = ($urandom_range(0, 299) != 0);
            tick();
        end
        START = 1'b1;
        repeat (3) tick();
        check("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
